// File: rtl/output_display_pkg.sv
// Shared constants and types for the processor-output display path:
// active-low 7-segment encodings, digit count and the conversion FSM encoding.
package output_display_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_LOAD,
    CONV_SHIFT,
    CONV_COMMIT
  } conv_state_e;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd3_t;

  function automatic logic [5:0] digit_enable(input logic [2:0] idx);
    return ~(6'b00_0001 << idx);
  endfunction

endpackage

// File: rtl/output_display_ctrl_if.sv
// Processor-side inputs and display-side outputs of the display controller,
// bundled so the processor (master) and the controller (slave) share one port.
interface output_display_ctrl_if;
  logic [7:0] Moutput;
  logic [3:0] DisplayState;
  logic [2:0] IR75;
  logic       Halt;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       conv_busy;

  modport master (
    output Moutput, DisplayState, IR75, Halt,
    input  seg, dp, an, conv_busy
  );

  modport slave (
    input  Moutput, DisplayState, IR75, Halt,
    output seg, dp, an, conv_busy
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit magnitude to three BCD digits in 8 shift cycles.
// load_o marks the cycle the operand is captured, done_o the cycle results are final.
module bin2bcd_seq
  import output_display_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] mag_i,
  output logic       load_o,
  output logic       done_o,
  output logic       busy_o,
  output bcd3_t      bcd_o
);

  conv_state_e state_q, state_d;
  logic [7:0]  mag_q, mag_d;
  bcd3_t       bcd_q, bcd_d, bcd_adj;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // NOTE: every always_comb target gets a default first so no path leaves it
  // unassigned; a missing default turns the signal into a latch.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    bcd_adj = {add3(bcd_q.hundreds), add3(bcd_q.tens), add3(bcd_q.units)};

    case (state_q)
      CONV_IDLE: begin
        if (start_i) state_d = CONV_LOAD;
      end
      CONV_LOAD: begin
        mag_d   = mag_i;
        bcd_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = CONV_SHIFT;
      end
      CONV_SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        cnt_d          = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = CONV_COMMIT;
      end
      CONV_COMMIT: begin
        busy_d  = 1'b0;
        state_d = CONV_IDLE;
      end
      default: state_d = CONV_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= CONV_IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign load_o = (state_q == CONV_LOAD);
  assign done_o = (state_q == CONV_COMMIT);
  assign busy_o = busy_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/output_display_ctrl.sv
// Shows the processor output register in decimal (with sign), the opcode and the
// FSM state on a 6-digit multiplexed active-low 7-segment display.
module output_display_ctrl
  import output_display_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter bit SIGNED   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  output_display_ctrl_if.slave  bus
);

  localparam int               CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

  logic [7:0] shadow_q;
  logic       neg_q;
  bcd3_t      disp_q;
  logic       sign_q;

  logic       in_neg;
  logic [7:0] in_mag;
  logic       conv_load, conv_done, conv_busy;
  bcd3_t      conv_bcd;

  // 8-bit two's-complement negate already maps 8'h80 to 128.
  assign in_neg = SIGNED && bus.Moutput[7];
  assign in_mag = in_neg ? (~bus.Moutput + 8'd1) : bus.Moutput;

  bin2bcd_seq u_bin2bcd (
    .clock   (clock),
    .reset   (reset),
    .start_i (bus.Moutput != shadow_q),
    .mag_i   (in_mag),
    .load_o  (conv_load),
    .done_o  (conv_done),
    .busy_o  (conv_busy),
    .bcd_o   (conv_bcd)
  );

  // Display digits only change on commit, so a partial result is never shown.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      neg_q    <= 1'b0;
      disp_q   <= '0;
      sign_q   <= 1'b0;
    end else begin
      if (conv_load) begin
        shadow_q <= bus.Moutput;
        neg_q    <= in_neg;
      end
      if (conv_done) begin
        disp_q <= conv_bcd;
        sign_q <= neg_q;
      end
    end
  end

  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [5:0]       an_q, an_d;

  always_comb begin
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end

    seg_d = SEG_BLANK;
    case (idx_q)
      3'd0:    seg_d = SEG_HEX[disp_q.units];
      3'd1:    seg_d = SEG_HEX[disp_q.tens];
      3'd2:    seg_d = SEG_HEX[disp_q.hundreds];
      3'd3:    seg_d = sign_q ? SEG_MINUS : SEG_BLANK;
      3'd4:    seg_d = SEG_HEX[{1'b0, bus.IR75}];
      3'd5:    seg_d = SEG_HEX[bus.DisplayState];
      default: seg_d = SEG_BLANK;
    endcase

    an_d = digit_enable(idx_q);
    dp_d = !((idx_q == 3'd0) && bus.Halt);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      an_q       <= 6'h3F;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.an        = an_q;
  assign bus.conv_busy = conv_busy;

endmodule
